// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the multiplexed 8-digit seven-segment scanner.
// Optional decimal-point support is enabled with DIGIT_SCAN_DP_EN.
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; element 0 is the glyph for hex 0.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/digit_scan_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
// Shared glyph table lives in digit_scan_pkg.
module hex7seg
  import digit_scan_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH[i_hex];

endmodule

// File: rtl/digit_scan.sv
// Time-multiplexed 8-digit scanner driving a 3-to-8 decoder and shared segments.
// Define DIGIT_SCAN_DP_EN to add the per-digit decimal point (LD_DP / DP).
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter logic [15:0] DIV       = 16'd1000,
  parameter logic [15:0] BLANK_CYC = 16'd50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       LD,
  input  logic [2:0] LD_IDX,
  input  logic [3:0] LD_DATA,
`ifdef DIGIT_SCAN_DP_EN
  input  logic       LD_DP,
  output logic       DP,
`endif
  output logic [2:0] A,
  output logic       G1,
  output logic       G2,
  output logic       G3,
  output logic [6:0] SEG,
  output logic       FRAME
);

  state_t                         r_state;
  logic   [15:0]                  r_cnt;
  logic   [2:0]                   r_idx;
  logic                           r_dec_on;
  logic                           r_frame;
  logic   [NUM_DIGITS-1:0][3:0]   r_mem;
  logic   [6:0]                   w_glyph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
    end else if (LD) begin
      r_mem[LD_IDX] <= LD_DATA;
    end
  end

  hex7seg u_hex7seg (
    .i_hex (r_mem[r_idx]),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_dec_on <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (EN) begin
            r_state <= BLANK;
            r_cnt   <= '0;
          end
        end
        BLANK: begin
          if (!EN) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_dec_on <= 1'b0;
          end else if (r_cnt == BLANK_CYC - 16'd1) begin
            r_state  <= SHOW;
            r_cnt    <= '0;
            r_dec_on <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        SHOW: begin
          if (!EN) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_dec_on <= 1'b0;
          end else if (r_cnt == DIV - 16'd1) begin
            r_state  <= BLANK;
            r_cnt    <= '0;
            r_dec_on <= 1'b0;
            r_idx    <= r_idx + 3'd1;
            r_frame  <= (r_idx == 3'd7);
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_dec_on <= 1'b0;
        end
      endcase
    end
  end

  // Segments track live register contents so writes show up immediately.
  assign A     = r_idx;
  assign G1    = r_dec_on;
  assign G2    = ~r_dec_on;
  assign G3    = ~r_dec_on;
  assign SEG   = r_dec_on ? w_glyph : SEG_OFF;
  assign FRAME = r_frame;

`ifdef DIGIT_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] r_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp <= '0;
    end else if (LD) begin
      r_dp[LD_IDX] <= LD_DP;
    end
  end

  assign DP = r_dec_on ? ~r_dp[r_idx] : 1'b1;
`endif

endmodule
